wb_stage_pipe: RTL

Parametrised MEM/WB pipeline stage register with a valid/ready handshake, synchronous flush, and an optional two-entry skid buffer. It carries write-back control (RegWrite, MemtoReg), memory read data, ALU result and destination register index from the memory stage to the write-back stage. It also exports a forwarding view of the held instruction for the hazard/forwarding unit. It replaces the fixed 16-bit, always-advancing MEM/WB latch, so the back end can stall and flush without losing or duplicating write-backs.

---
 rtl/wb_stage_pipe_pkg.sv | 33 +++
 rtl/wb_stage_pipe_skid_slot.sv | 29 ++
 rtl/wb_stage_pipe.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/wb_stage_pipe_pkg.sv
// Shared MEM/WB pipeline types: write-back payload, occupancy states, forwarding mux.
// Used by wb_stage_pipe; the WB_STAGE_SKID_EN build option lives in the top.
package wb_stage_pipe_pkg;

    localparam int WB_DATA_W  = 16;
    localparam int WB_IDX_W   = 4;
    // Widest data path fwd_select can serve; instances narrower than this zero-extend.
    localparam int MAX_DATA_W = 64;

    typedef struct packed {
        logic                 reg_write;
        logic                 memto_reg;
        logic [WB_DATA_W-1:0] data_out;
        logic [WB_DATA_W-1:0] result;
        logic [WB_IDX_W-1:0]  reg_write_index;
    } wb_payload_t;

    // Encoding equals {main_v, skid_v}, so the valid bits are the state register.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_FULL  = 2'b11
    } wb_state_e;

    function automatic logic [MAX_DATA_W-1:0] fwd_select(
        input logic                  memto_reg,
        input logic [MAX_DATA_W-1:0] data_out,
        input logic [MAX_DATA_W-1:0] result
    );
        return memto_reg ? data_out : result;
    endfunction

endpackage

// File: rtl/wb_stage_pipe_skid_slot.sv
// One pipeline slot: valid bit plus payload register with load and clear.
// Rst zeroes everything; clear only drops the valid bit.
module pipe_skid_slot #(
    parameter int W = 8
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    // NOTE: non-blocking assignments so every slot samples the pre-edge values of the others.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            valid <= 1'b0;
            // NOTE: payload is reset too, so the held outputs read 0 after Rst, not stale data.
            q     <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end
    end

endmodule

// File: rtl/wb_stage_pipe.sv
// MEM/WB stage register with valid/ready handshake, flush and forwarding view.
// Define WB_STAGE_SKID_EN for a two-entry skid buffer with registered InReady.
module wb_stage_pipe
    import wb_stage_pipe_pkg::*;
#(
    parameter int DATA_W       = WB_DATA_W,
    parameter int IDX_W        = WB_IDX_W,
    parameter bit HAS_ZERO_REG = 1'b1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Flush,
    input  logic              InValid,
    output logic              InReady,
    input  logic              RegWrite2,
    input  logic              MemotoReg2,
    input  logic [DATA_W-1:0] DataOut2,
    input  logic [DATA_W-1:0] Result2,
    input  logic [IDX_W-1:0]  RegWriteIndex2,
    output logic              OutValid,
    input  logic              OutReady,
    output logic              RegWrite3,
    output logic              MemotoReg3,
    output logic [DATA_W-1:0] DataOut3,
    output logic [DATA_W-1:0] Result3,
    output logic [IDX_W-1:0]  RegWriteIndex3,
    output logic              FwdValid,
    output logic [IDX_W-1:0]  FwdIndex,
    output logic [DATA_W-1:0] FwdData
);

    // Same layout as wb_payload_t, at this instance's widths.
    typedef struct packed {
        logic              reg_write;
        logic              memto_reg;
        logic [DATA_W-1:0] data_out;
        logic [DATA_W-1:0] result;
        logic [IDX_W-1:0]  reg_write_index;
    } payload_t;

    payload_t in_pl;
    payload_t main_d;
    payload_t main_q;
    logic     main_v;
    logic     main_load;
    logic     main_clear;
    logic     in_fire;
    logic     out_fire;

    assign in_pl = '{
        reg_write:       RegWrite2,
        memto_reg:       MemotoReg2,
        data_out:        DataOut2,
        result:          Result2,
        reg_write_index: RegWriteIndex2
    };

    assign in_fire  = InValid & InReady & ~Flush;
    assign out_fire = main_v & OutReady;

`ifdef WB_STAGE_SKID_EN
    payload_t  skid_q;
    logic      skid_v;
    logic      skid_load;
    logic      skid_clear;
    logic      main_from_skid;
    wb_state_e state;

    // Registered ready: depends only on skid occupancy, never on OutReady.
    assign InReady = ~skid_v & ~Rst;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        main_load      = 1'b0;
        main_clear     = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        main_from_skid = 1'b0;
        state          = wb_state_e'({main_v, skid_v});
        if (Flush) begin
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            case (state)
                ST_EMPTY: main_load = in_fire;
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_load = 1'b1;
                    end else if (in_fire) begin
                        skid_load = 1'b1;
                    end else if (out_fire) begin
                        main_clear = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clear     = 1'b1;
                    end
                end
                default: skid_clear = 1'b1;  // skid without main: drop it and fall back to EMPTY
            endcase
        end
    end

    assign main_d = main_from_skid ? skid_q : in_pl;

    pipe_skid_slot #(.W($bits(payload_t))) u_skid (
        .Clk   (Clk),
        .Rst   (Rst),
        .load  (skid_load),
        .clear (skid_clear),
        .d     (in_pl),
        .valid (skid_v),
        .q     (skid_q)
    );
`else
    assign InReady    = (OutReady | ~main_v) & ~Rst;
    assign main_load  = in_fire;
    assign main_clear = Flush | (out_fire & ~in_fire);
    assign main_d     = in_pl;
`endif

    pipe_skid_slot #(.W($bits(payload_t))) u_main (
        .Clk   (Clk),
        .Rst   (Rst),
        .load  (main_load),
        .clear (main_clear),
        .d     (main_d),
        .valid (main_v),
        .q     (main_q)
    );

    assign OutValid       = main_v;
    assign RegWrite3      = main_q.reg_write & main_v;
    assign MemotoReg3     = main_q.memto_reg;
    assign DataOut3       = main_q.data_out;
    assign Result3        = main_q.result;
    assign RegWriteIndex3 = main_q.reg_write_index;

    // Forwarding sees the main slot only; a skid-held producer is covered by InReady=0.
    assign FwdValid = RegWrite3 & (!HAS_ZERO_REG || (main_q.reg_write_index != '0));
    assign FwdIndex = main_q.reg_write_index;
    assign FwdData  = DATA_W'(fwd_select(main_q.memto_reg,
                                         MAX_DATA_W'(main_q.data_out),
                                         MAX_DATA_W'(main_q.result)));

endmodule
